// File: rtl/sqrt_display_n.sv
// Bit-serial integer square root with a scanned, leading-zero-blanked 7-segment readout.
// A free-running double-dabble converter feeds the display from operand, root or remainder.
module sqrt_display_n #(
   parameter int unsigned WIDTH        = 16,
   parameter int unsigned DIGITS       = 4,
   parameter int unsigned REFRESH_BITS = 17
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic [WIDTH-1:0]     a,
   input  logic                 start,
   input  logic                 show_rem,
   output logic [6:0]           ag,
   output logic [DIGITS-1:0]    an,
   output logic                 valid,
   output logic                 busy,
   output logic [WIDTH/2-1:0]   root,
   output logic [WIDTH/2:0]     rem
);

   localparam int unsigned HW    = WIDTH / 2;
   localparam int unsigned RW    = HW + 2;
   localparam int unsigned IW    = $clog2(HW);
   localparam int unsigned CW    = $clog2(WIDTH + 1);
   localparam int unsigned NBMIN = (WIDTH * 3) / 10 + 1;
   localparam int unsigned NBCD  = (NBMIN > DIGITS) ? NBMIN : DIGITS;
   localparam int unsigned BW    = 4 * NBCD;
   localparam int unsigned DW    = 4 * DIGITS;
   localparam int unsigned DIW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SQRT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_ZERO  = 7'h40;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // ---------------- square-root engine ----------------
   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [RW-1:0]    r_q, r_d;
   logic [HW-1:0]    q_q, q_d;
   logic [IW-1:0]    it_q, it_d;
   logic [HW-1:0]    root_q, root_d;
   logic [HW:0]      rem_q, rem_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;

   logic [RW-1:0]    r_sh, t_try, r_it;
   logic [HW-1:0]    q_it;

   // One restoring iteration: bring down two operand bits, trial-subtract 4q+1.
   always_comb begin
      r_sh  = {r_q[RW-3:0], x_q[WIDTH-1 -: 2]};
      t_try = {q_q, 2'b01};
      r_it  = r_sh;
      q_it  = {q_q[HW-2:0], 1'b0};
      if (r_sh >= t_try) begin
         r_it = r_sh - t_try;
         q_it = {q_q[HW-2:0], 1'b1};
      end
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      r_d     = r_q;
      q_d     = q_q;
      it_d    = it_q;
      root_d  = root_q;
      rem_d   = rem_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_SQRT;
               x_d     = a;
               r_d     = '0;
               q_d     = '0;
               it_d    = '0;
               busy_d  = 1'b1;
               valid_d = 1'b0;
            end
         end
         S_SQRT: begin
            x_d  = {x_q[WIDTH-3:0], 2'b00};
            r_d  = r_it;
            q_d  = q_it;
            it_d = IW'(it_q + IW'(1));
            if (it_q == IW'(HW - 1)) begin
               state_d = S_DONE;
               root_d  = q_it;
               rem_d   = r_it[HW:0];
               busy_d  = 1'b0;
               valid_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         r_q     <= '0;
         q_q     <= '0;
         it_q    <= '0;
         root_q  <= '0;
         rem_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         r_q     <= r_d;
         q_q     <= q_d;
         it_q    <= it_d;
         root_q  <= root_d;
         rem_q   <= rem_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   // ---------------- binary-to-BCD converter ----------------
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic [BW-1:0]    bcd_q, bcd_d;
   logic [DW-1:0]    disp_q, disp_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH-1:0] src;
   logic [BW-1:0]    bcd_adj, bcd_sh;

   always_comb begin
      src = valid_q ? (show_rem ? WIDTH'(rem_q) : WIDTH'(root_q)) : a;
      bcd_adj = bcd_q;
      for (int unsigned i = 0; i < NBCD; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      bcd_sh = {bcd_adj[BW-2:0], bin_q[WIDTH-1]};
   end

   // Load on count 0, then WIDTH shifts; the finished pass is published in one edge.
   always_comb begin
      cnt_d  = cnt_q;
      bin_d  = bin_q;
      bcd_d  = bcd_q;
      disp_d = disp_q;
      ovf_d  = ovf_q;
      if (cnt_q == '0) begin
         bin_d = src;
         bcd_d = '0;
         cnt_d = CW'(1);
      end else begin
         bin_d = {bin_q[WIDTH-2:0], 1'b0};
         bcd_d = bcd_sh;
         if (cnt_q == CW'(WIDTH)) begin
            cnt_d  = '0;
            disp_d = bcd_sh[DW-1:0];
            ovf_d  = |(bcd_sh >> DW);
         end else begin
            cnt_d = CW'(cnt_q + CW'(1));
         end
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         cnt_q  <= '0;
         bin_q  <= '0;
         bcd_q  <= '0;
         disp_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         bin_q  <= bin_d;
         bcd_q  <= bcd_d;
         disp_q <= disp_d;
         ovf_q  <= ovf_d;
      end
   end

   // ---------------- digit scan ----------------
   logic [REFRESH_BITS-1:0] pre_q, pre_d;
   logic [DIW-1:0]          dig_q, dig_d;
   logic [DIGITS-1:0]       an_q, an_d;
   logic [6:0]              ag_q, ag_d;
   logic [DIGITS-1:0]       shown;
   logic                    seen;
   logic [3:0]              cur_dig;
   logic                    cur_shown;

   always_comb begin
      pre_d = REFRESH_BITS'(pre_q + REFRESH_BITS'(1));
      dig_d = dig_q;
      if (&pre_q) dig_d = (dig_q == DIW'(DIGITS - 1)) ? '0 : DIW'(dig_q + DIW'(1));

      // A digit is lit if it or any more significant digit is nonzero; ones always lit.
      seen  = 1'b0;
      shown = '0;
      for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
         seen     = seen | (disp_q[4*i +: 4] != 4'd0);
         shown[i] = seen | (i == 0);
      end

      cur_dig   = 4'd0;
      cur_shown = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (dig_d == DIW'(i)) begin
            cur_dig   = disp_q[4*i +: 4];
            cur_shown = shown[i];
         end
      end

      an_d = ~(DIGITS'(1) << dig_d);
      if (ovf_q)           ag_d = SEG_DASH;
      else if (!cur_shown) ag_d = SEG_BLANK;
      else                 ag_d = seg7(cur_dig);
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         pre_q <= '0;
         dig_q <= '0;
         an_q  <= ~DIGITS'(1);
         ag_q  <= SEG_ZERO;
      end else begin
         pre_q <= pre_d;
         dig_q <= dig_d;
         an_q  <= an_d;
         ag_q  <= ag_d;
      end
   end

   assign ag    = ag_q;
   assign an    = an_q;
   assign valid = valid_q;
   assign busy  = busy_q;
   assign root  = root_q;
   assign rem   = rem_q;

endmodule

// File: tb/tb_sqrt_display_n.sv
// Bench for sqrt_display_n: vector table of roots/remainders plus display, reset and timing sequences.
module tb_sqrt_display_n;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        clr;
   logic [15:0] a;
   logic        start, show_rem;
   logic [6:0]  ag;
   logic [3:0]  an;
   logic        valid, busy;
   logic [7:0]  root;
   logic [8:0]  rem;

   logic [15:0] a2;
   logic        start2, show2;
   logic [6:0]  ag2;
   logic [1:0]  an2;
   logic        valid2, busy2;
   logic [7:0]  root2;
   logic [8:0]  rem2;

   logic [7:0]  a8;
   logic        start8, show8;
   logic [6:0]  ag8;
   logic [3:0]  an8;
   logic        valid8, busy8;
   logic [3:0]  root8;
   logic [4:0]  rem8;

   sqrt_display_n #(.WIDTH(16), .DIGITS(4), .REFRESH_BITS(2)) u_dut (
      .clk(clk), .clr(clr), .a(a), .start(start), .show_rem(show_rem),
      .ag(ag), .an(an), .valid(valid), .busy(busy), .root(root), .rem(rem));

   sqrt_display_n #(.WIDTH(16), .DIGITS(2), .REFRESH_BITS(2)) u_d2 (
      .clk(clk), .clr(clr), .a(a2), .start(start2), .show_rem(show2),
      .ag(ag2), .an(an2), .valid(valid2), .busy(busy2), .root(root2), .rem(rem2));

   sqrt_display_n #(.WIDTH(8), .DIGITS(4), .REFRESH_BITS(2)) u_w8 (
      .clk(clk), .clr(clr), .a(a8), .start(start8), .show_rem(show8),
      .ag(ag8), .an(an8), .valid(valid8), .busy(busy8), .root(root8), .rem(rem8));

   int checks   = 0;
   int failures = 0;

   logic [6:0] seg_m [4];
   logic [6:0] seg_2 [2];

   typedef struct {
      logic [15:0] a;
      int          root;
      int          rem;
   } vec_t;
   vec_t vecs [9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Expected active-low pattern of digit idx for value v on an nd-digit display.
   function automatic logic [6:0] exp_seg(input int v, input int nd, input int idx);
      int lim = 1;
      int p   = 1;
      logic [6:0] s;
      for (int k = 0; k < nd; k++) lim = lim * 10;
      for (int k = 0; k < idx; k++) p = p * 10;
      if (v >= lim) return 7'h3F;
      if (idx > 0 && v < p) return 7'h7F;
      case ((v / p) % 10)
         0: s = 7'h40;  1: s = 7'h79;  2: s = 7'h24;  3: s = 7'h30;  4: s = 7'h19;
         5: s = 7'h12;  6: s = 7'h02;  7: s = 7'h78;  8: s = 7'h00;  default: s = 7'h10;
      endcase
      return s;
   endfunction

   task automatic scan_main();
      for (int i = 0; i < 4; i++) seg_m[i] = 7'hxx;
      repeat (40) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) if (an == ~(4'b0001 << i)) seg_m[i] = ag;
      end
   endtask

   task automatic scan_d2();
      for (int i = 0; i < 2; i++) seg_2[i] = 7'hxx;
      repeat (24) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) if (an2 == ~(2'b01 << i)) seg_2[i] = ag2;
      end
   endtask

   task automatic check_disp_main(input int v, input string tag);
      repeat (40) @(posedge clk);
      scan_main();
      for (int i = 0; i < 4; i++)
         chk($sformatf("%s_dig%0d", tag, i), 64'(seg_m[i]), 64'(exp_seg(v, 4, i)));
   endtask

   task automatic check_disp_d2(input int v, input int settle, input string tag);
      repeat (settle) @(posedge clk);
      scan_d2();
      for (int i = 0; i < 2; i++)
         chk($sformatf("%s_dig%0d", tag, i), 64'(seg_2[i]), 64'(exp_seg(v, 2, i)));
   endtask

   task automatic run_main(input logic [15:0] v, output int lat, output int bc);
      @(negedge clk);
      a = v;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      bc  = busy ? 1 : 0;
      while (!valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
         if (busy) bc++;
      end
   endtask

   initial begin
      int lat, bc, n, q;
      int rises[$];
      logic prev;

      vecs[0] = '{16'd0,     0,   0};
      vecs[1] = '{16'd255,   15,  30};
      vecs[2] = '{16'd65535, 255, 510};
      vecs[3] = '{16'd50000, 223, 271};
      vecs[4] = '{16'd99,    9,   18};
      vecs[5] = '{16'd100,   10,  0};
      vecs[6] = '{16'd1,     1,   0};
      vecs[7] = '{16'd2,     1,   1};
      vecs[8] = '{16'd10000, 100, 0};

      clr = 1'b1; a = '0; start = 1'b0; show_rem = 1'b0;
      a2 = '0; start2 = 1'b0; show2 = 1'b0;
      a8 = '0; start8 = 1'b0; show8 = 1'b0;
      #2 clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 64'(valid), 64'(0));
      chk("rst_busy",  64'(busy),  64'(0));
      chk("rst_root",  64'(root),  64'(0));
      chk("rst_rem",   64'(rem),   64'(0));
      chk("rst_an",    64'(an),    64'(4'b1110));
      chk("rst_ag",    64'(ag),    64'(7'h40));
      @(negedge clk);
      clr = 1'b1;

      // Table: root, remainder, latency, busy length, and both display selections.
      for (int k = 0; k < 9; k++) begin
         show_rem = 1'b0;
         run_main(vecs[k].a, lat, bc);
         chk($sformatf("v%0d_latency", k), 64'(lat),  64'(9));
         chk($sformatf("v%0d_busy",    k), 64'(bc),   64'(8));
         chk($sformatf("v%0d_root",    k), 64'(root), 64'(vecs[k].root));
         chk($sformatf("v%0d_rem",     k), 64'(rem),  64'(vecs[k].rem));
         check_disp_main(vecs[k].root, $sformatf("v%0d_disp_root", k));
         show_rem = 1'b1;
         check_disp_main(vecs[k].rem, $sformatf("v%0d_disp_rem", k));
         show_rem = 1'b0;
      end
      chk("done_hold_valid", 64'(valid), 64'(1));

      // Second start while computing is ignored.
      @(negedge clk);
      a = 16'd65535;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      repeat (3) begin @(posedge clk); #1; lat++; end
      @(negedge clk);
      a = 16'd4;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      while (!valid && lat < 50) begin @(posedge clk); #1; lat++; end
      chk("ign_latency", 64'(lat),  64'(9));
      chk("ign_root",    64'(root), 64'(255));
      chk("ign_rem",     64'(rem),  64'(510));
      repeat (5) @(posedge clk);
      #1;
      chk("ign_hold_valid", 64'(valid), 64'(1));
      chk("ign_hold_root",  64'(root),  64'(255));

      // start held high in DONE restarts every 9 cycles.
      @(negedge clk);
      a = 16'd255;
      start = 1'b1;
      prev = valid;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (valid && !prev) rises.push_back(c);
         prev = valid;
      end
      start = 1'b0;
      chk("hold_rises_ge2", 64'(rises.size() >= 2), 64'(1));
      if (rises.size() >= 2) begin
         chk("hold_first_rise", 64'(rises[0]), 64'(9));
         chk("hold_period",     64'(rises[1] - rises[0]), 64'(9));
      end
      chk("hold_root", 64'(root), 64'(15));
      repeat (12) @(posedge clk);

      // Reset mid-computation aborts cleanly.
      @(negedge clk);
      a = 16'd50000;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 clr = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(valid), 64'(0));
      chk("mid_rst_busy",  64'(busy),  64'(0));
      chk("mid_rst_root",  64'(root),  64'(0));
      chk("mid_rst_rem",   64'(rem),   64'(0));
      chk("mid_rst_an",    64'(an),    64'(4'b1110));
      chk("mid_rst_ag",    64'(ag),    64'(7'h40));
      @(negedge clk);
      clr = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("post_rst_valid", 64'(valid), 64'(0));
      chk("post_rst_busy",  64'(busy),  64'(0));
      chk("post_rst_root",  64'(root),  64'(0));
      check_disp_main(50000, "post_rst_operand_ovf");
      a = 16'd42;
      check_disp_main(42, "post_rst_operand");
      run_main(16'd50000, lat, bc);
      chk("rerun_latency", 64'(lat),  64'(9));
      chk("rerun_root",    64'(root), 64'(223));
      chk("rerun_rem",     64'(rem),  64'(271));

      // Two-digit display: overflow dashes, worst-case update lag, blanking.
      @(negedge clk);
      a2 = 16'd65535;
      check_disp_d2(65535, 40, "d2_ovf");
      @(negedge clk);
      a2 = 16'd99;
      check_disp_d2(99, 34, "d2_99");
      @(negedge clk);
      a2 = 16'd5;
      check_disp_d2(5, 40, "d2_5");
      @(negedge clk);
      a2 = 16'd100;
      check_disp_d2(100, 40, "d2_100");
      chk("d2_idle_valid", 64'(valid2), 64'(0));

      // Exhaustive 8-bit sweep against a reference root.
      for (int v = 0; v < 256; v++) begin
         @(negedge clk);
         a8 = 8'(v);
         start8 = 1'b1;
         @(posedge clk); #1;
         start8 = 1'b0;
         n = 1;
         while (!valid8 && n < 30) begin @(posedge clk); #1; n++; end
         q = 0;
         while ((q + 1) * (q + 1) <= v) q++;
         chk($sformatf("w8_lat_%0d",  v), 64'(n),     64'(5));
         chk($sformatf("w8_root_%0d", v), 64'(root8), 64'(q));
         chk($sformatf("w8_rem_%0d",  v), 64'(rem8),  64'(v - q * q));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
